// File: rtl/mmu_pkg.sv
// Types and constants shared by the TLBs and the MMU page walker.
package mmu_pkg;

  localparam int unsigned PAGE_OFFSET_BITS = 12;
  localparam int unsigned VPN_BITS         = 9;

  // Field order mirrors PTE bits [7:0].
  typedef struct packed {
    logic d;
    logic a;
    logic g;
    logic u;
    logic x;
    logic w;
    logic r;
    logic v;
  } tlb_perm_bits;

  typedef enum logic [1:0] {
    TLB_IDLE,
    TLB_WAIT,
    TLB_FILL
  } TLB_State;

endpackage

// File: rtl/tlb_cache_if.sv
// Page-walk request/response channel between a TLB (master) and the MMU (slave).
interface tlb_cache_if;
  import mmu_pkg::*;

  logic         mmu_req_valid;
  logic [63:0]  mmu_req_addr;
  logic         mmu_resp_valid;
  logic [63:0]  mmu_resp_addr;
  tlb_perm_bits mmu_resp_perms;

  modport master (
    output mmu_req_valid,
    output mmu_req_addr,
    input  mmu_resp_valid,
    input  mmu_resp_addr,
    input  mmu_resp_perms
  );

  modport slave (
    input  mmu_req_valid,
    input  mmu_req_addr,
    output mmu_resp_valid,
    output mmu_resp_addr,
    output mmu_resp_perms
  );

endinterface

// File: rtl/tlb_cache_cam.sv
// Parallel tag compare across all entries; lowest matching index wins.
module tlb_cam #(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned TAG_W   = 36,
  parameter int unsigned IDX_W   = 3
) (
  input  logic [ENTRIES-1:0]            valid_i,
  input  logic [ENTRIES-1:0][TAG_W-1:0] tags_i,
  input  logic [TAG_W-1:0]              tag_i,
  output logic                          hit_o,
  output logic [IDX_W-1:0]              idx_o
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!found && valid_i[i] && (tags_i[i] == tag_i)) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

  assign hit_o = found;
  assign idx_o = idx;

endmodule

// File: rtl/tlb_cache.sv
// Fully-associative 4 KiB TLB with round-robin replacement; misses are
// resolved through a single outstanding page-walk request to the MMU.
module tlb_cache
  import mmu_pkg::*;
#(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned VA_BITS = 48
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         lookup_valid,
  input  logic [63:0]  lookup_vaddr,
  output logic         lookup_hit,
  output logic [63:0]  lookup_paddr,
  output tlb_perm_bits lookup_perms,
  output logic         busy,
  input  logic         flush,
  tlb_cache_if.master  mmu
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = VA_BITS - PAGE_OFFSET_BITS;
  localparam int unsigned PPN_W = 64 - PAGE_OFFSET_BITS;

  TLB_State                            state_q, state_d;
  logic         [ENTRIES-1:0]            valid_q;
  logic         [ENTRIES-1:0][TAG_W-1:0] tag_q;
  logic         [ENTRIES-1:0][PPN_W-1:0] ppn_q;
  tlb_perm_bits [ENTRIES-1:0]            perms_q;
  logic         [IDX_W-1:0]              rr_q;
  logic         [PPN_W-1:0]              miss_vpn_q;
  logic         [PPN_W-1:0]              resp_ppn_q;
  tlb_perm_bits                          resp_perms_q;
  logic                                  discard_q;

  logic             cam_hit;
  logic [IDX_W-1:0] cam_idx;

  tlb_cam #(
    .ENTRIES (ENTRIES),
    .TAG_W   (TAG_W),
    .IDX_W   (IDX_W)
  ) u_cam (
    .valid_i (valid_q),
    .tags_i  (tag_q),
    .tag_i   (lookup_vaddr[VA_BITS-1:PAGE_OFFSET_BITS]),
    .hit_o   (cam_hit),
    .idx_o   (cam_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= TLB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLB_IDLE: if (lookup_valid && !cam_hit && !flush) state_d = TLB_WAIT;
      TLB_WAIT: if (mmu.mmu_resp_valid)                 state_d = TLB_FILL;
      TLB_FILL:                                         state_d = TLB_IDLE;
      default:                                          state_d = TLB_IDLE;
    endcase
  end

  always_comb begin
    busy              = (state_q != TLB_IDLE);
    mmu.mmu_req_valid = (state_q == TLB_WAIT);
    mmu.mmu_req_addr  = {miss_vpn_q, {PAGE_OFFSET_BITS{1'b0}}};
    lookup_hit        = lookup_valid && (state_q == TLB_IDLE) && cam_hit;
    lookup_paddr      = '0;
    lookup_perms      = '0;
    if (lookup_hit) begin
      lookup_paddr = {ppn_q[cam_idx], lookup_vaddr[PAGE_OFFSET_BITS-1:0]};
      lookup_perms = perms_q[cam_idx];
    end
  end

  // A flush during the walk cannot abort the MMU, so it is remembered and
  // turns the eventual fill into a no-op (rr pointer included).
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q      <= '0;
      rr_q         <= '0;
      miss_vpn_q   <= '0;
      resp_ppn_q   <= '0;
      resp_perms_q <= '0;
      discard_q    <= 1'b0;
    end else begin
      case (state_q)
        TLB_IDLE: begin
          if (flush) valid_q <= '0;
          else if (lookup_valid && !cam_hit)
            miss_vpn_q <= lookup_vaddr[63:PAGE_OFFSET_BITS];
        end
        TLB_WAIT: begin
          if (flush) discard_q <= 1'b1;
          if (mmu.mmu_resp_valid) begin
            resp_ppn_q   <= mmu.mmu_resp_addr[63:PAGE_OFFSET_BITS];
            resp_perms_q <= mmu.mmu_resp_perms;
          end
        end
        TLB_FILL: begin
          discard_q <= 1'b0;
          if (flush) valid_q <= '0;
          else if (!discard_q) begin
            valid_q[rr_q] <= 1'b1;
            tag_q[rr_q]   <= miss_vpn_q[TAG_W-1:0];
            ppn_q[rr_q]   <= resp_ppn_q;
            perms_q[rr_q] <= resp_perms_q;
            rr_q          <= rr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  a_resp_aligned : assert property (@(posedge clk) disable iff (!reset)
    mmu.mmu_resp_valid |-> (mmu.mmu_resp_addr[PAGE_OFFSET_BITS-1:0] == '0))
    else $error("tlb_cache: mmu_resp_addr not page aligned: %h", mmu.mmu_resp_addr);

endmodule
